// File: rtl/fpu_tx_pkg.sv
// Shared types for the FPU result transmitter: FSM states, FIFO entry layout, byte indexing.
// FPU_RESULT_TX_PARITY_EN appends an XOR parity byte to every serialized element.
package fpu_tx_pkg;

  localparam int DATA_W     = 32;
  localparam int DATA_BYTES = DATA_W / 8;

`ifdef FPU_RESULT_TX_PARITY_EN
  localparam int NBYTES = DATA_BYTES + 2;
`else
  localparam int NBYTES = DATA_BYTES + 1;
`endif

  localparam int IDX_W = $clog2(NBYTES);

  typedef logic [IDX_W-1:0] byte_idx_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  typedef struct packed {
    logic              last;
    logic [7:0]        flags;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

  // Data bytes go out LSB first; the index right after the data selects the flags.
  function automatic logic [7:0] entry_byte(input fifo_entry_t e, input byte_idx_t idx);
    logic [7:0] b;
    b = e.flags;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (idx == byte_idx_t'(i)) b = e.data[i*8 +: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/fpu_tx_fifo.sv
// Synchronous FIFO buffering FPU result entries; writes ignored when full, reads when empty.
module fpu_tx_fifo #(
  parameter int W     = 41,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wr_en,
  input  logic [W-1:0]             i_wr_data,
  input  logic                     i_rd_en,
  output logic [W-1:0]             o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_push    = i_wr_en && !o_full;
  assign w_pop     = i_rd_en && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/fpu_result_tx.sv
// Buffers FPU results with flags and serializes each into an LSB-first byte stream.
// FPU_RESULT_TX_PARITY_EN adds a trailing XOR parity byte that carries tx_eop/tx_eom.
module fpu_result_tx
  import fpu_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,   // must equal fpu_tx_pkg::DATA_W
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          res_valid,
  output logic                          res_ready,
  input  logic [DATA_WIDTH-1:0]         res_data,
  input  logic [7:0]                    res_flags,
  input  logic                          res_last,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [7:0]                    tx_byte,
  output logic                          tx_sop,
  output logic                          tx_eop,
  output logic                          tx_eom,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output state_t                        dbg_state
);

  // Handshakes: a beat moves on a rising edge where valid && ready; the source
  // holds its payload stable and never withdraws valid until that beat completes.

  state_t      r_state;
  state_t      w_state_nxt;
  byte_idx_t   r_idx;
  byte_idx_t   w_idx_nxt;
  fifo_entry_t r_elem;
  fifo_entry_t w_head;
  fifo_entry_t w_wr_entry;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_xfer;
  logic        w_last_byte;
  logic [7:0]  w_cur_byte;

  assign w_wr_entry = {res_last, res_flags, res_data};
  assign res_ready  = !w_full;

  fpu_tx_fifo #(
    .W     (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (res_valid),
    .i_wr_data (w_wr_entry),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (level)
  );

  assign w_xfer      = tx_valid && tx_ready;
  assign w_last_byte = (r_idx == byte_idx_t'(NBYTES - 1));

`ifdef FPU_RESULT_TX_PARITY_EN
  logic [7:0] r_parity;

  always_comb begin
    w_cur_byte = entry_byte(r_elem, r_idx);
    if (w_last_byte) w_cur_byte = r_parity;
  end

  // Running XOR of the bytes already sent; restarts whenever a new element loads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_parity <= '0;
    end else if (w_pop) begin
      r_parity <= '0;
    end else if (w_xfer) begin
      r_parity <= r_parity ^ w_cur_byte;
    end
  end
`else
  assign w_cur_byte = entry_byte(r_elem, r_idx);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_xfer) begin
          if (!w_last_byte) begin
            w_idx_nxt = r_idx + byte_idx_t'(1);
          end else if (!w_empty) begin
            // Chain straight into the next element without an idle bubble.
            w_pop     = 1'b1;
            w_idx_nxt = '0;
          end else begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_elem  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_pop) r_elem <= w_head;
    end
  end

  always_comb begin
    tx_valid = (r_state == ST_SEND);
    tx_byte  = tx_valid ? w_cur_byte : 8'h00;
    tx_sop   = tx_valid && (r_idx == '0);
    tx_eop   = tx_valid && w_last_byte;
    tx_eom   = tx_eop && r_elem.last;
  end

  assign dbg_state = r_state;

endmodule
